// File: rtl/cam_frame_ctrl.sv
// cam_frame_ctrl
// Frame-level capture controller sitting between the camera sensor pins and the
// byte-pairing pixel capture block. It arms on command and waits for a vertical
// blank. It then passes exactly one whole frame (single mode) or successive whole
// frames (continuous mode) downstream. Each frame's geometry is checked. The
// write bank of a double-buffered frame store flips only on good frames.
//
// Parameters:
//   LINES       href pulses expected per frame
//   LINE_BYTES  href-high cycles expected per line (2 bytes per RGB565 pixel)
// Ports:
//   clk, rst_n             pixel clock (rising edge) / async active-low reset
//   vsync, href, d         raw sensor sync lines and data byte
//   cmd_start, cmd_mode    arm pulse and mode (0 single, 1 continuous)
//   cmd_stop               stop pulse (a frame in progress still completes)
//   vsync_o, href_o, d_o   gated/registered sensor lines to the capture block
//   wr_buf, rd_buf         bank being written / bank for display (always ~wr_buf)
//   busy                   controller not idle
//   frame_ok, frame_err    one-cycle completion pulses
//   frame_cnt, err_cnt     good-frame count (wraps), bad-frame count (saturates)
module cam_frame_ctrl #(
    parameter int unsigned LINES      = 240,
    parameter int unsigned LINE_BYTES = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    input  logic        cmd_start,
    input  logic        cmd_mode,
    input  logic        cmd_stop,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        wr_buf,
    output logic        rd_buf,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] SYNC    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    localparam logic [9:0]  LINES_W = 10'(LINES);
    localparam logic [11:0] BYTES_W = 12'(LINE_BYTES);

    logic [1:0]  state_q, state_d;
    logic        mode_q, mode_d;
    logic        stop_pend_q, stop_pend_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic        bad_q, bad_d;
    logic        wr_buf_q, wr_buf_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        vsync_q, href_q;
    logic [7:0]  d_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        line_cnt_d  = line_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        bad_d       = bad_q;
        wr_buf_d    = wr_buf_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                // A start colliding with a stop is treated as a stop.
                if (cmd_start && !cmd_stop) begin
                    state_d = ARM;
                    mode_d  = cmd_mode;
                end
            end
            ARM: begin
                // Only a blank proves we are at a frame boundary.
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (vsync) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (cmd_stop) begin
                    state_d = IDLE;
                end else if (!vsync) begin
                    state_d    = CAPTURE;
                    line_cnt_d = '0;
                    byte_cnt_d = '0;
                    bad_d      = 1'b0;
                end
            end
            CAPTURE: begin
                if (cmd_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (href && !href_q) begin
                    if (line_cnt_q != 10'h3ff) begin
                        line_cnt_d = line_cnt_q + 10'd1;
                    end
                    byte_cnt_d = 12'd1;
                end else if (href && href_q) begin
                    if (byte_cnt_q != 12'hfff) begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                end else if (!href && href_q && (byte_cnt_q != BYTES_W)) begin
                    bad_d = 1'b1;
                end

                if (vsync) begin
                    // href_q high here means vsync cut the last line short.
                    if ((line_cnt_q == LINES_W) && !bad_q && !href_q) begin
                        frame_ok_d  = 1'b1;
                        wr_buf_d    = ~wr_buf_q;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_cnt_q != 8'hff) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                    if (mode_q && !stop_pend_q && !cmd_stop) begin
                        state_d = SYNC;
                    end else begin
                        state_d = IDLE;
                    end
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            line_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            bad_q       <= 1'b0;
            wr_buf_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            line_cnt_q  <= line_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            bad_q       <= bad_d;
            wr_buf_q    <= wr_buf_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            vsync_q     <= vsync;
            href_q      <= href;
            d_q         <= d;
        end
    end

    // Blank is forced whenever not capturing, so downstream never sees a partial frame.
    assign vsync_o   = vsync_q | (state_q != CAPTURE);
    assign href_o    = href_q & (state_q == CAPTURE);
    assign d_o       = d_q;
    assign wr_buf    = wr_buf_q;
    assign rd_buf    = ~wr_buf_q;
    assign busy      = (state_q != IDLE);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Self-checking bench for cam_frame_ctrl with a reduced frame geometry.
// A frame-level model tracks the capture session and the line lengths seen. It
// predicts every output each cycle. Literal checks pin the key scenario results.
module tb_cam_frame_ctrl;

    localparam int unsigned NL = 4;
    localparam int unsigned NB = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic        href = 1'b0;
    logic [7:0]  d = 8'd0;
    logic        cmd_start = 1'b0;
    logic        cmd_mode = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        vsync_o, href_o, wr_buf, rd_buf, busy, frame_ok, frame_err;
    logic [7:0]  d_o, err_cnt;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    cam_frame_ctrl #(.LINES(NL), .LINE_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_stop(cmd_stop),
        .vsync_o(vsync_o), .href_o(href_o), .d_o(d_o), .wr_buf(wr_buf), .rd_buf(rd_buf),
        .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    int checks = 0;
    int failures = 0;
    int n_ok = 0, n_err = 0, n_href = 0;

    // Model: session phase bits plus the list of completed line lengths.
    bit m_armed, m_seen_blank, m_in_frame, m_mode, m_stop_req, m_p_hr;
    int m_run;
    int m_lens[$];
    bit e_vs, e_hr, e_ok, e_err, e_wr, e_busy;
    logic [7:0]  e_d, e_ec;
    logic [15:0] e_fc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_armed = 0; m_seen_blank = 0; m_in_frame = 0; m_mode = 0; m_stop_req = 0;
        m_p_hr = 0; m_run = 0; m_lens.delete();
        e_vs = 1; e_hr = 0; e_ok = 0; e_err = 0; e_wr = 0; e_busy = 0;
        e_d = 8'd0; e_ec = 8'd0; e_fc = 16'd0;
    endfunction

    function automatic void model_edge();
        bit good;
        e_ok = 0;
        e_err = 0;
        if (!m_armed) begin
            if (cmd_start && !cmd_stop) begin
                m_armed = 1; m_mode = cmd_mode; m_seen_blank = 0; m_in_frame = 0;
            end
        end else if (!m_in_frame) begin
            if (cmd_stop) m_armed = 0;
            else if (!m_seen_blank) begin
                if (vsync) m_seen_blank = 1;
            end else if (!vsync) begin
                m_in_frame = 1; m_run = 0; m_lens.delete();
            end
        end else begin
            if (cmd_stop) m_stop_req = 1;
            if (vsync) begin
                good = !m_p_hr && (m_lens.size() == NL);
                foreach (m_lens[i]) if (m_lens[i] != NB) good = 0;
                if (good) begin
                    e_ok = 1; e_wr = !e_wr; e_fc = e_fc + 16'd1;
                end else begin
                    e_err = 1;
                    if (e_ec != 8'hff) e_ec = e_ec + 8'd1;
                end
                m_in_frame = 0;
                if (m_mode && !m_stop_req) m_seen_blank = 1;
                else m_armed = 0;
                m_stop_req = 0;
            end else if (href) begin
                m_run++;
            end else if (m_p_hr) begin
                m_lens.push_back(m_run);
                m_run = 0;
            end
        end
        m_p_hr = href;
        e_vs = vsync | !m_in_frame;
        e_hr = href & m_in_frame;
        e_d = d;
        e_busy = m_armed;
    endfunction

    always @(negedge clk) begin
        chk("vsync_o", 32'(vsync_o), 32'(e_vs));
        chk("href_o", 32'(href_o), 32'(e_hr));
        chk("d_o", 32'(d_o), 32'(e_d));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("wr_buf", 32'(wr_buf), 32'(e_wr));
        chk("rd_buf", 32'(rd_buf), 32'(!e_wr));
        chk("frame_ok", 32'(frame_ok), 32'(e_ok));
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_fc));
        chk("err_cnt", 32'(err_cnt), 32'(e_ec));
        if (frame_ok === 1'b1) n_ok++;
        if (frame_err === 1'b1) n_err++;
        if (href_o === 1'b1) n_href++;
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
    endtask

    task automatic blank(input int n);
        vsync = 1'b1;
        href = 1'b0;
        repeat (n) step();
    endtask

    // act: 1 stop, 2 start single, 3 start continuous, 4 reset pulse
    task automatic do_act(input int act);
        case (act)
            1: cmd_stop = 1'b1;
            2: begin cmd_mode = 1'b0; cmd_start = 1'b1; end
            3: begin cmd_mode = 1'b1; cmd_start = 1'b1; end
            4: begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("rst vsync_o", 32'(vsync_o), 32'd1);
                chk("rst href_o", 32'(href_o), 32'd0);
                chk("rst busy", 32'(busy), 32'd0);
                chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
                chk("rst err_cnt", 32'(err_cnt), 32'd0);
                chk("rst wr_buf", 32'(wr_buf), 32'd0);
                step();
                step();
                rst_n = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Blank, porch, then lines; a truncated frame ends with href still high.
    task automatic frame(input int nlines, input int short_idx, input bit trunc,
                         input int act_line, input int act);
        blank(4);
        vsync = 1'b0;
        href = 1'b0;
        repeat (2) step();
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_idx) ? int'(NB) - 2 : int'(NB);
            if (trunc && l == nlines - 1) len = 3;
            if (l == act_line) do_act(act);
            for (int b = 0; b < len; b++) begin
                href = 1'b1;
                d = 8'($urandom);
                step();
            end
            if (!(trunc && l == nlines - 1)) begin
                href = 1'b0;
                d = 8'd0;
                repeat (3) step();
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        chk("init vsync_o", 32'(vsync_o), 32'd1);
        chk("init href_o", 32'(href_o), 32'd0);
        chk("init busy", 32'(busy), 32'd0);
        chk("init rd_buf", 32'(rd_buf), 32'd1);

        // Single clean frame, armed during blank.
        blank(3);
        n_ok = 0; n_href = 0;
        cmd_mode = 1'b0; cmd_start = 1'b1;
        step();
        chk("single busy rise", 32'(busy), 32'd1);
        frame(NL, -1, 0, -1, 0);
        blank(6);
        chk("single ok pulses", 32'(n_ok), 32'd1);
        chk("single frame_cnt", 32'(frame_cnt), 32'd1);
        chk("single wr_buf", 32'(wr_buf), 32'd1);
        chk("single rd_buf", 32'(rd_buf), 32'd0);
        chk("single busy", 32'(busy), 32'd0);
        chk("single href bytes", 32'(n_href), 32'(NL * NB));

        // Continuous: three clean frames, stop mid fourth.
        n_ok = 0;
        cmd_mode = 1'b1; cmd_start = 1'b1;
        step();
        repeat (3) frame(NL, -1, 0, -1, 0);
        frame(NL, -1, 0, 2, 1);
        blank(6);
        chk("cont ok pulses", 32'(n_ok), 32'd4);
        chk("cont frame_cnt", 32'(frame_cnt), 32'd5);
        chk("cont wr_buf", 32'(wr_buf), 32'd1);
        chk("cont busy", 32'(busy), 32'd0);

        // Arm mid-frame: that frame is skipped, the next one captured.
        n_ok = 0; n_href = 0;
        frame(NL, -1, 0, 2, 2);
        chk("midarm no href", 32'(n_href), 32'd0);
        chk("midarm busy", 32'(busy), 32'd1);
        frame(NL, -1, 0, -1, 0);
        blank(6);
        chk("midarm ok pulses", 32'(n_ok), 32'd1);
        chk("midarm frame_cnt", 32'(frame_cnt), 32'd6);
        chk("midarm href bytes", 32'(n_href), 32'(NL * NB));
        chk("midarm wr_buf", 32'(wr_buf), 32'd0);

        // Bad frames: short line, missing line, truncated line (with stop).
        n_ok = 0; n_err = 0;
        cmd_mode = 1'b1; cmd_start = 1'b1;
        step();
        frame(NL, 1, 0, -1, 0);
        frame(NL - 1, -1, 0, -1, 0);
        chk("bad first err_cnt", 32'(err_cnt), 32'd1);
        chk("bad first wr_buf", 32'(wr_buf), 32'd0);
        frame(NL, -1, 1, 0, 1);
        blank(6);
        chk("bad err pulses", 32'(n_err), 32'd3);
        chk("bad err_cnt", 32'(err_cnt), 32'd3);
        chk("bad no ok", 32'(n_ok), 32'd0);
        chk("bad frame_cnt", 32'(frame_cnt), 32'd6);
        chk("bad busy", 32'(busy), 32'd0);

        // Reset in the middle of a continuous capture.
        cmd_mode = 1'b1; cmd_start = 1'b1;
        step();
        frame(NL, -1, 0, -1, 0);
        frame(NL, -1, 0, 2, 4);
        n_ok = 0; n_href = 0;
        frame(NL, -1, 0, -1, 0);
        blank(6);
        chk("post-rst no capture", 32'(n_href), 32'd0);
        chk("post-rst no ok", 32'(n_ok), 32'd0);
        chk("post-rst busy", 32'(busy), 32'd0);

        // Start and stop together in idle.
        cmd_start = 1'b1; cmd_stop = 1'b1;
        step();
        chk("start+stop busy", 32'(busy), 32'd0);
        step();
        chk("start+stop busy later", 32'(busy), 32'd0);

        // Stop while armed.
        n_ok = 0; n_err = 0;
        vsync = 1'b0; href = 1'b0;
        step();
        cmd_mode = 1'b0; cmd_start = 1'b1;
        step();
        chk("arm busy", 32'(busy), 32'd1);
        cmd_stop = 1'b1;
        step();
        chk("arm stop busy", 32'(busy), 32'd0);
        blank(4);
        chk("arm stop no ok", 32'(n_ok), 32'd0);
        chk("arm stop no err", 32'(n_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_frame_ctrl.md
# cam_frame_ctrl

Frame-level capture controller placed between the OV-series sensor pins and the byte-pairing pixel capture block that writes the frame RAM. It arms capture on command, aligns to frame boundaries, and gates the sensor sync lines so downstream capture only ever sees whole frames. It validates each frame's geometry and manages a double-buffered frame store by flipping the write bank only on good frames. The display side always reads the last complete frame.

## Interface
- LINES, default 240: href pulses expected per frame.
- LINE_BYTES, default 640: bytes (href-high cycles) expected per line; 2 bytes per RGB565 pixel.
- clk  in  1  pixel clock (sensor pclk); all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vsync  in  1  sensor vsync, high = vertical blank; synchronous to clk.
- href  in  1  sensor href, high = valid line bytes.
- d  in  8  sensor data byte.
- cmd_start  in  1  one-cycle pulse: arm capture.
- cmd_mode  in  1  0 = single frame, 1 = continuous; sampled with cmd_start.
- cmd_stop  in  1  one-cycle pulse: stop capture.
- vsync_o  out  1  gated vsync to capture block.
- href_o  out  1  gated href to capture block.
- d_o  out  8  data byte, delayed to align with href_o.
- wr_buf  out  1  frame bank being written.
- rd_buf  out  1  frame bank for display, always ~wr_buf.
- busy  out  1  state != IDLE.
- frame_ok  out  1  one-cycle pulse: good frame completed.
- frame_err  out  1  one-cycle pulse: bad frame completed.
- frame_cnt  out  16  good-frame count, wraps.
- err_cnt  out  8  bad-frame count, saturates at 255.

## Operation
- Input registers vsync_q, href_q, d_q load every cycle; d_o = d_q.
- Outputs: vsync_o = vsync_q | (state != CAPTURE); href_o = href_q & (state == CAPTURE).
- States: IDLE, ARM, SYNC, CAPTURE.
- IDLE: cmd_start -> ARM; mode_r <= cmd_mode. cmd_start with cmd_stop in the same cycle: stay IDLE.
- ARM: waits for vsync = 1, then -> SYNC. cmd_stop -> IDLE.
- SYNC: in blank; vsync = 0 sampled -> CAPTURE, clear line_cnt, byte_cnt, bad. cmd_stop -> IDLE.
- CAPTURE line counting:
  - href = 1 and href_q = 0: line_cnt += 1, saturating at 1023; byte_cnt <= 1.
  - href = 1 and href_q = 1: byte_cnt += 1, saturating at 4095.
  - href = 0 and href_q = 1: if byte_cnt != LINE_BYTES, set bad.
- CAPTURE, cmd_stop: set stop_pend; the frame in progress completes normally.
- CAPTURE, frame end (vsync = 1 sampled):
  - Good when line_cnt == LINES, bad == 0, and href_q == 0 (line not truncated by vsync).
  - Good: frame_ok pulse, wr_buf toggles, frame_cnt += 1.
  - Otherwise: frame_err pulse, err_cnt += 1 (saturating), wr_buf unchanged.
  - Next state: SYNC if mode_r = 1 and no stop_pend; else IDLE. stop_pend clears on every exit.
- cmd_start outside IDLE is ignored.
- Reset values: state IDLE, vsync_q 1, href_q 0, d_q 0, wr_buf 0, all counters 0, stop_pend 0, pulses 0. Hence vsync_o = 1, href_o = 0, rd_buf = 1, busy = 0.

## Timing
- Datapath latency: d/href/vsync to d_o/href_o/vsync_o is 1 cycle.
- Entering CAPTURE: the state and vsync_q update on the same edge, so vsync_o falls exactly when vsync_q falls. The downstream block sees no partial blank.
- Frame end: vsync_o rises on the edge that samples vsync = 1. frame_ok/frame_err and the wr_buf toggle are registered on that same edge, each high for one cycle.
- Arming mid-frame (vsync = 0): stays in ARM until the next blank, so the first captured frame is always whole.
- Reset asserted mid-frame: immediate async clear. vsync_o = 1 forces the downstream address back to 0.
- busy rises 1 cycle after cmd_start. busy falls 1 cycle after the final frame-end sample or after cmd_stop in ARM/SYNC.

## Test plan
- Single mode, clean 240x640 frame: pulse cmd_start during blank. Expect:
  - exactly one frame_ok, frame_cnt = 1, wr_buf = 1, rd_buf = 0;
  - busy = 0 afterwards;
  - href_o high for exactly 240x640 cycles.
- Continuous mode, 3 clean frames, then cmd_stop mid-frame 4 -> frame 4 completes, 4 frame_ok pulses, frame_cnt = 4, wr_buf = 0, then IDLE.
- cmd_start while vsync = 0 with 100 lines already elapsed -> href_o stays 0 until the next blank. The next whole frame is captured with frame_ok.
- Bad frames:
  - one 638-byte line -> frame_err, err_cnt = 1, wr_buf unchanged;
  - 239-line frame -> frame_err;
  - vsync rising while href is high -> frame_err.
- rst_n low for 2 cycles at line 120 of a continuous capture -> vsync_o = 1, href_o = 0, busy = 0, counters 0 immediately. No further capture without a new cmd_start.
- cmd_start with cmd_stop in the same IDLE cycle -> busy stays 0.
- cmd_stop in ARM -> IDLE next cycle, no pulses.
